// File: rtl/dct_seq_pkg.sv
// Shared types and constants for the 8x8 DCT block sequencer.
// ZIGZAG is used only when DCT_ZIGZAG_EN is defined.
package dct_seq_pkg;

  typedef enum logic [1:0] {FILL, SETTLE, DRAIN} seq_state_t;

  localparam int BLK_N = 64;

  // JPEG zig-zag scan: beat i reads coefficient ZIGZAG[i]
  localparam logic [5:0] ZIGZAG [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Unsigned pixel minus 2^(pix_w-1). Evaluated at 32 bits, which gives the
  // same value as a (pix_w+1)-bit subtract followed by sign extension.
  function automatic logic signed [31:0] level_shift(input logic [15:0] pix,
                                                     input int pix_w);
    return signed'({16'b0, pix}) - (32'sd1 <<< (pix_w - 1));
  endfunction

endpackage

// File: rtl/dct_coef_reg_rd.sv
// 64-entry captured coefficient register with order-mapped read port.
// With DCT_ZIGZAG_EN defined the read index goes through the zig-zag table,
// otherwise coefficients are read row-major.
module dct_coef_reg_rd
  import dct_seq_pkg::*;
#(
  parameter int IN_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_i,
  input  logic [BLK_N*IN_W-1:0] coef_flat_i,
  input  logic [5:0]            rd_idx_i,
  output logic [IN_W-1:0]       coef_o
);

  logic [BLK_N-1:0][IN_W-1:0] coef_q;
  logic [5:0]                 addr;

`ifdef DCT_ZIGZAG_EN
  assign addr = ZIGZAG[rd_idx_i];
`else
  assign addr = rd_idx_i;
`endif

  // Snapshot the whole DCT output once the settle window has elapsed
  always_ff @(posedge clk) begin
    if (rst)        coef_q <= '0;
    else if (cap_i) coef_q <= coef_flat_i;
  end

  assign coef_o = coef_q[addr];

endmodule

// File: rtl/dct8x8_block_seq.sv
// Streaming wrapper around the combinational 8x8 DCT: fills a level-shifted
// input buffer, waits SETTLE_CYCLES for the multicycle DCT path, captures the
// result and drains it while the next block fills.
// Optional build macro: DCT_ZIGZAG_EN (zig-zag output order).
module dct8x8_block_seq
  import dct_seq_pkg::*;
#(
  parameter int IN_W          = 32,
  parameter int PIX_W         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PIX_W-1:0]      s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [IN_W-1:0]       m_data,
  output logic                  m_last,
  output logic [BLK_N*IN_W-1:0] dct_din_flat,
  input  logic [BLK_N*IN_W-1:0] dct_dout_flat,
  output logic                  busy
);

  seq_state_t                 state_q;
  logic [BLK_N-1:0][IN_W-1:0] buf_q;
  logic [5:0]                 wr_idx_q;
  logic [5:0]                 rd_idx_q;
  logic                       in_full_q;
  logic [3:0]                 settle_cnt_q;

  logic accept, out_hs, last_in, last_out, capture;

  // Handshake qualifiers are built only from registered state (and rst)
  assign s_ready  = !rst && (state_q != SETTLE) && !in_full_q;
  assign m_valid  = !rst && (state_q == DRAIN);
  assign m_last   = m_valid && (rd_idx_q == 6'd63);
  assign busy     = !rst && ((state_q != FILL) || (wr_idx_q != 6'd0));

  assign accept   = s_valid && s_ready;
  assign out_hs   = m_valid && m_ready;
  assign last_in  = accept && (wr_idx_q == 6'd63);
  assign last_out = out_hs && (rd_idx_q == 6'd63);
  assign capture  = (state_q == SETTLE) && (settle_cnt_q == 4'd0);

  assign dct_din_flat = buf_q;

  // Sequencer FSM plus input buffer writes; input may fill during DRAIN
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      buf_q        <= '0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      in_full_q    <= 1'b0;
      settle_cnt_q <= '0;
    end else begin
      if (accept) begin
        buf_q[wr_idx_q] <= IN_W'(level_shift(16'(s_data), PIX_W));
        wr_idx_q        <= wr_idx_q + 6'd1;  // wraps to 0 after entry 63
        if (last_in) in_full_q <= 1'b1;
      end
      case (state_q)
        FILL: begin
          if (last_in) begin
            state_q      <= SETTLE;
            settle_cnt_q <= 4'(SETTLE_CYCLES - 1);
          end
        end
        SETTLE: begin
          if (capture) begin
            state_q   <= DRAIN;
            in_full_q <= 1'b0;
            rd_idx_q  <= '0;
          end else begin
            settle_cnt_q <= settle_cnt_q - 4'd1;
          end
        end
        DRAIN: begin
          if (out_hs) rd_idx_q <= rd_idx_q + 6'd1;
          if (last_out) begin
            if (in_full_q || last_in) begin
              state_q      <= SETTLE;
              settle_cnt_q <= 4'(SETTLE_CYCLES - 1);
            end else begin
              state_q <= FILL;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  dct_coef_reg_rd #(.IN_W(IN_W)) u_coef (
    .clk         (clk),
    .rst         (rst),
    .cap_i       (capture),
    .coef_flat_i (dct_dout_flat),
    .rd_idx_i    (rd_idx_q),
    .coef_o      (m_data)
  );

endmodule
